// File: rtl/lsh_pkg.sv
// Shared types and constants for the LSH window pipeline (feeder and hasher side).
package lsh_pkg;

    localparam int SKETCH_SIZE    = 16;
    localparam int NUM_OF_BUCKETS = 256;
    localparam int WINDOW_SIZE    = 128;
    localparam int BUCKET_W       = $clog2(NUM_OF_BUCKETS);
    localparam int FILL_CNT_W     = $clog2(WINDOW_SIZE + 1);

    typedef logic [1:0]            base_t;
    typedef logic [BUCKET_W-1:0]   bucket_t;
    typedef logic [FILL_CNT_W-1:0] fill_cnt_t;

    typedef enum logic {
        FILL = 1'b0,
        REQ  = 1'b1
    } feeder_state_t;

    // Bases needed before the next request: a whole window at sequence start, else one stride.
    function automatic fill_cnt_t fill_target(input logic first_win, input int stride);
        return first_win ? fill_cnt_t'(WINDOW_SIZE) : fill_cnt_t'(stride);
    endfunction

endpackage

// File: rtl/base_shift_window.sv
// DEPTH x 2-bit shift register: new bases enter at the top, index 0 holds the oldest.
module base_shift_window
    import lsh_pkg::*;
#(
    parameter int DEPTH = WINDOW_SIZE
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  shift_en,
    input  base_t shift_in,
    output base_t window [0:DEPTH-1]
);

    base_t win_q [0:DEPTH-1];
    base_t win_d [0:DEPTH-1];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            win_d[i] = win_q[i];
        end
        if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[DEPTH-1] = shift_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
            assign window[gi] = win_q[gi];
        end
    endgenerate

endmodule

// File: rtl/window_feeder.sv
// Feeds sliding base windows to window_hasher and buffers the returned sketches
// (one entry, index-tagged) towards a valid/ready consumer.
module window_feeder
    import lsh_pkg::*;
#(
    parameter int STRIDE = 32,
    parameter int IDX_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base_valid,
    input  base_t            base_data,
    input  logic             base_first,
    output logic             base_ready,
    output base_t            window [0:WINDOW_SIZE-1],
    output logic             ready_for_hashing,
    input  bucket_t          hashedSketch [0:SKETCH_SIZE-1],
    input  logic             hashing_is_done,
    output bucket_t          sketch_out [0:SKETCH_SIZE-1],
    output logic [IDX_W-1:0] sketch_idx,
    output logic             sketch_valid,
    input  logic             sketch_ready
);

    feeder_state_t    state_q, state_d;
    fill_cnt_t        fill_cnt_q, fill_cnt_d;
    logic             first_win_q, first_win_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    bucket_t          sketch_q [0:SKETCH_SIZE-1];
    bucket_t          sketch_d [0:SKETCH_SIZE-1];
    logic [IDX_W-1:0] sketch_idx_q, sketch_idx_d;
    logic             sketch_valid_q, sketch_valid_d;

    logic             base_accept;
    fill_cnt_t        cnt_post;
    logic             first_post;

    // Once the count has reached its target the window must not move until the request is issued.
    assign base_ready  = !reset && (state_q == FILL) &&
                         (fill_cnt_q < fill_target(first_win_q, STRIDE));
    assign base_accept = base_valid && base_ready;

    base_shift_window #(
        .DEPTH    (WINDOW_SIZE)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .shift_en (base_accept),
        .shift_in (base_data),
        .window   (window)
    );

    always_comb begin
        state_d        = state_q;
        fill_cnt_d     = fill_cnt_q;
        first_win_d    = first_win_q;
        win_idx_d      = win_idx_q;
        sketch_idx_d   = sketch_idx_q;
        sketch_valid_d = sketch_valid_q && !sketch_ready;
        for (int i = 0; i < SKETCH_SIZE; i++) begin
            sketch_d[i] = sketch_q[i];
        end
        cnt_post   = fill_cnt_q;
        first_post = first_win_q;

        unique case (state_q)
            FILL: begin
                if (base_accept) begin
                    if (base_first) begin
                        cnt_post   = fill_cnt_t'(1);
                        first_post = 1'b1;
                        win_idx_d  = '0;
                    end else begin
                        cnt_post = fill_cnt_q + fill_cnt_t'(1);
                    end
                end
                fill_cnt_d  = cnt_post;
                first_win_d = first_post;
                // A full buffer holds off the request, so a capture can never overwrite it.
                if ((cnt_post == fill_target(first_post, STRIDE)) && !sketch_valid_q) begin
                    state_d     = REQ;
                    fill_cnt_d  = '0;
                    first_win_d = 1'b0;
                end
            end
            REQ: begin
                if (hashing_is_done) begin
                    for (int i = 0; i < SKETCH_SIZE; i++) begin
                        sketch_d[i] = hashedSketch[i];
                    end
                    sketch_idx_d   = win_idx_q;
                    sketch_valid_d = 1'b1;
                    win_idx_d      = win_idx_q + IDX_W'(1);
                    state_d        = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            fill_cnt_q     <= '0;
            first_win_q    <= 1'b1;
            win_idx_q      <= '0;
            sketch_idx_q   <= '0;
            sketch_valid_q <= 1'b0;
            for (int i = 0; i < SKETCH_SIZE; i++) begin
                sketch_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            first_win_q    <= first_win_d;
            win_idx_q      <= win_idx_d;
            sketch_idx_q   <= sketch_idx_d;
            sketch_valid_q <= sketch_valid_d;
            for (int i = 0; i < SKETCH_SIZE; i++) begin
                sketch_q[i] <= sketch_d[i];
            end
        end
    end

    assign ready_for_hashing = (state_q == REQ);
    assign sketch_idx        = sketch_idx_q;
    assign sketch_valid      = sketch_valid_q;

    generate
        for (genvar gi = 0; gi < SKETCH_SIZE; gi++) begin : g_sketch
            assign sketch_out[gi] = sketch_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_window_feeder.sv
// Randomized scoreboard bench for window_feeder with a behavioural hasher and sink.
module tb_window_feeder;
    import lsh_pkg::*;

    localparam int STRIDE = 32;
    localparam int IDX_W  = 16;
    localparam int WIN_BITS = 2 * WINDOW_SIZE;
    localparam int SK_BITS  = BUCKET_W * SKETCH_SIZE;

    typedef struct packed {
        logic [WIN_BITS-1:0] win;
        logic [IDX_W-1:0]    idx;
        longint              tgt;
    } req_t;

    typedef struct packed {
        logic [SK_BITS-1:0] sk;
        logic [IDX_W-1:0]   idx;
    } out_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             base_valid;
    base_t            base_data;
    logic             base_first;
    logic             base_ready;
    base_t            window [0:WINDOW_SIZE-1];
    logic             ready_for_hashing;
    bucket_t          hashedSketch [0:SKETCH_SIZE-1];
    logic             hashing_is_done;
    bucket_t          sketch_out [0:SKETCH_SIZE-1];
    logic [IDX_W-1:0] sketch_idx;
    logic             sketch_valid;
    logic             sketch_ready;

    window_feeder #(
        .STRIDE            (STRIDE),
        .IDX_W             (IDX_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .base_valid        (base_valid),
        .base_data         (base_data),
        .base_first        (base_first),
        .base_ready        (base_ready),
        .window            (window),
        .ready_for_hashing (ready_for_hashing),
        .hashedSketch      (hashedSketch),
        .hashing_is_done   (hashing_is_done),
        .sketch_out        (sketch_out),
        .sketch_idx        (sketch_idx),
        .sketch_valid      (sketch_valid),
        .sketch_ready      (sketch_ready)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_checks = 0;
    int     n_pass   = 0;
    req_t   req_q[$];
    out_t   out_q[$];
    base_t  seq[$];
    int     seq_n = 0;
    longint last_hs = -100;
    int     n_rise = 0;
    bit     busy = 0;
    bit     hold_done = 0;
    bit     spur_req = 0;
    bit     lat_mode = 0;
    int     sink_mode = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [WIN_BITS-1:0] dut_win();
        logic [WIN_BITS-1:0] w;
        for (int i = 0; i < WINDOW_SIZE; i++) w[2*i +: 2] = window[i];
        return w;
    endfunction

    function automatic logic [SK_BITS-1:0] dut_sk();
        logic [SK_BITS-1:0] s;
        for (int i = 0; i < SKETCH_SIZE; i++) s[BUCKET_W*i +: BUCKET_W] = sketch_out[i];
        return s;
    endfunction

    // Reference: a request is due whenever the sequence holds 128 + k*STRIDE bases;
    // its window is the newest 128 bases and its tag is k.
    task automatic model_accept(input base_t d, input bit first);
        req_t r;
        if (first) begin
            seq.delete();
            seq_n = 0;
        end
        seq.push_back(d);
        seq_n++;
        if (seq.size() > WINDOW_SIZE) void'(seq.pop_front());
        if (seq_n >= WINDOW_SIZE && ((seq_n - WINDOW_SIZE) % STRIDE) == 0) begin
            for (int i = 0; i < WINDOW_SIZE; i++) r.win[2*i +: 2] = seq[i];
            r.idx = IDX_W'((seq_n - WINDOW_SIZE) / STRIDE);
            r.tgt = cyc;
            req_q.push_back(r);
        end
    endtask

    task automatic model_reset();
        seq.delete();
        seq_n = 0;
    endtask

    task automatic send_bases(input int n, input int vpct, input int first_at,
                              input bit rand_first, input bit incr_data);
        int sent = 0;
        int t = 0;
        while (sent < n && t < 5000) begin
            @(posedge clk); #1;
            base_valid = ($urandom_range(99) < vpct);
            base_data  = incr_data ? base_t'(sent % 4) : base_t'($urandom_range(3));
            base_first = (sent == first_at) || (rand_first && $urandom_range(299) == 0);
            @(negedge clk);
            if (base_valid && base_ready) begin
                model_accept(base_data, base_first);
                sent++;
            end
            t++;
        end
        @(posedge clk); #1;
        base_valid = 1'b0;
        base_first = 1'b0;
        chk(sent == n, "send_done", $sformatf("accepted %0d bases, required %0d", sent, n));
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while ((req_q.size() != 0 || out_q.size() != 0 || busy || ready_for_hashing || sketch_valid)
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(t < 3000, {"idle_", nm}, $sformatf("pending req=%0d out=%0d after %0d cycles, required 0",
            req_q.size(), out_q.size(), t));
    endtask

    // Hasher model: checks each request against the scoreboard, answers after a latency.
    initial begin
        req_t   cur;
        out_t   o;
        int     cnt;
        bit     rfh_prev;
        longint exp_rise;
        cur = '0;
        cnt = 0;
        rfh_prev = 1'b0;
        hashing_is_done = 1'b0;
        for (int i = 0; i < SKETCH_SIZE; i++) hashedSketch[i] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0;
                rfh_prev = 1'b0;
            end else begin
                if (ready_for_hashing)
                    chk(!base_ready, "no_base_in_req", $sformatf("base_ready=%0b, required 0", base_ready));
                if (ready_for_hashing && !rfh_prev) begin
                    n_rise++;
                    chk(req_q.size() != 0, "unexpected_req", $sformatf("request at cycle %0d, none expected", cyc));
                    if (req_q.size() != 0) begin
                        cur = req_q.pop_front();
                        chk(dut_win() == cur.win, "req_window",
                            $sformatf("got %h required %h", dut_win(), cur.win));
                        exp_rise = (cur.tgt + 1 > last_hs + 2) ? cur.tgt + 1 : last_hs + 2;
                        chk(cyc == exp_rise, "req_timing",
                            $sformatf("rose at cycle %0d, required %0d", cyc, exp_rise));
                        busy = 1'b1;
                        cnt = lat_mode ? int'($urandom_range(12, 1)) : 10;
                    end
                end
                rfh_prev = ready_for_hashing;
            end
            @(posedge clk); #1;
            hashing_is_done = 1'b0;
            if (spur_req) begin
                for (int i = 0; i < SKETCH_SIZE; i++) hashedSketch[i] = bucket_t'($urandom);
                hashing_is_done = 1'b1;
                spur_req = 1'b0;
            end else if (busy && !hold_done) begin
                if (cnt <= 1) begin
                    for (int i = 0; i < SKETCH_SIZE; i++) begin
                        hashedSketch[i] = bucket_t'($urandom);
                        o.sk[BUCKET_W*i +: BUCKET_W] = hashedSketch[i];
                    end
                    o.idx = cur.idx;
                    out_q.push_back(o);
                    hashing_is_done = 1'b1;
                    busy = 1'b0;
                    chk(dut_win() == cur.win, "win_stable",
                        $sformatf("got %h required %h", dut_win(), cur.win));
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Downstream sink: compares every accepted sketch with the scoreboard.
    initial begin
        out_t o;
        sketch_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (sink_mode)
                0:       sketch_ready = 1'b1;
                1:       sketch_ready = 1'($urandom_range(1));
                default: sketch_ready = 1'b0;
            endcase
            @(negedge clk);
            if (!reset && sketch_valid && sketch_ready) begin
                last_hs = cyc;
                chk(out_q.size() != 0, "unexpected_sketch", $sformatf("sketch idx %0d at cycle %0d, none expected", sketch_idx, cyc));
                if (out_q.size() != 0) begin
                    o = out_q.pop_front();
                    chk(sketch_idx == o.idx, "sketch_idx", $sformatf("got %0d required %0d", sketch_idx, o.idx));
                    chk(dut_sk() == o.sk, "sketch_out", $sformatf("got %h required %h", dut_sk(), o.sk));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int t;
        reset = 1'b1;
        base_valid = 1'b0;
        base_data = '0;
        base_first = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!base_ready, "rst_base_ready", $sformatf("got %0b required 0", base_ready));
        chk(!ready_for_hashing, "rst_rfh", $sformatf("got %0b required 0", ready_for_hashing));
        chk(!sketch_valid, "rst_sketch_valid", $sformatf("got %0b required 0", sketch_valid));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(dut_win() == '0, "rst_window", $sformatf("got %h required 0", dut_win()));
        chk(dut_sk() == '0, "rst_sketch_out", $sformatf("got %h required 0", dut_sk()));
        chk(sketch_idx == '0, "rst_sketch_idx", $sformatf("got %0d required 0", sketch_idx));
        chk(base_ready, "rst_fill_ready", $sformatf("got %0b required 1", base_ready));

        // Continuous stream of 192 bases with pattern i%4: three requests
        r0 = n_rise;
        send_bases(192, 100, -1, 1'b0, 1'b1);
        wait_idle("stream192");
        chk(n_rise - r0 == 3, "req_count_192", $sformatf("got %0d requests required 3", n_rise - r0));

        // Downstream stalled: second window must wait for the buffer to drain
        sink_mode = 2;
        send_bases(64, 100, -1, 1'b0, 1'b0);
        r0 = n_rise;
        repeat (200) @(negedge clk);
        chk(!base_ready, "stall_base_ready", $sformatf("got %0b required 0", base_ready));
        chk(!ready_for_hashing, "stall_rfh", $sformatf("got %0b required 0", ready_for_hashing));
        chk(sketch_valid, "stall_sketch_valid", $sformatf("got %0b required 1", sketch_valid));
        chk(n_rise == r0, "stall_no_req", $sformatf("got %0d extra requests required 0", n_rise - r0));
        sink_mode = 0;
        wait_idle("stall");

        // New sequence started mid-stream at base #150, random gaps and latency
        sink_mode = 1;
        lat_mode = 1'b1;
        send_bases(318, 80, 149, 1'b0, 1'b0);
        wait_idle("first150");

        // Fully random traffic including occasional sequence restarts
        send_bases(500, 70, -1, 1'b1, 1'b0);
        wait_idle("random");

        // Reset while a request is outstanding, then a late completion pulse
        sink_mode = 0;
        lat_mode = 1'b0;
        hold_done = 1'b1;
        send_bases(128, 100, 0, 1'b0, 1'b0);
        t = 0;
        while (!ready_for_hashing && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(ready_for_hashing, "abort_req_seen", $sformatf("rfh=%0b required 1", ready_for_hashing));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk(!base_ready, "abort_rst_base_ready", $sformatf("got %0b required 0", base_ready));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        hold_done = 1'b0;
        @(negedge clk);
        spur_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(!sketch_valid, "abort_sketch_valid", $sformatf("got %0b required 0", sketch_valid));
        end
        chk(!ready_for_hashing, "abort_rfh", $sformatf("got %0b required 0", ready_for_hashing));
        chk(sketch_idx == '0, "abort_sketch_idx", $sformatf("got %0d required 0", sketch_idx));
        chk(dut_sk() == '0, "abort_sketch_out", $sformatf("got %h required 0", dut_sk()));
        chk(dut_win() == '0, "abort_window", $sformatf("got %h required 0", dut_win()));
        chk(base_ready, "abort_fill", $sformatf("got %0b required 1", base_ready));

        // Spurious completions in FILL with the buffer full, then empty
        sink_mode = 2;
        send_bases(128, 100, -1, 1'b0, 1'b0);
        t = 0;
        while (!(out_q.size() == 1 && !busy && sketch_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(t < 500, "spur_setup", $sformatf("buffer not filled after %0d cycles, required < 500", t));
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        chk(sketch_valid, "spur_full_valid", $sformatf("got %0b required 1", sketch_valid));
        chk(!ready_for_hashing, "spur_full_rfh", $sformatf("got %0b required 0", ready_for_hashing));
        sink_mode = 0;
        wait_idle("spur_full");
        spur_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(!sketch_valid, "spur_empty_valid", $sformatf("got %0b required 0", sketch_valid));
        end
        send_bases(32, 100, -1, 1'b0, 1'b0);
        wait_idle("spur_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
